mgmt_tach_bank: RTL and testbench



---
 rtl/mgmt_tach_pkg.sv | 19 +
 rtl/mgmt_tach_channel.sv | 124 ++++++++++++
 rtl/mgmt_tach_bank.sv | 84 ++++++++
 tb/tb_mgmt_tach_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_tach_pkg.sv
// Shared types and helpers for the multi-channel fan tachometer bank.
// Optional MGMT_TACH_AVERAGE_EN build uses AVG_DEPTH/AVG_SHIFT for per-channel averaging.
package mgmt_tach_pkg;

  localparam int RPM_WIDTH = 16;
  typedef logic [RPM_WIDTH-1:0] rpm_t;
  localparam rpm_t RPM_MAX = '1;

  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

  // Edge count times RPM scale, clamped to the 16-bit RPM range.
  function automatic rpm_t sat_mul_rpm(input logic [15:0] edges, input logic [31:0] scale);
    logic [31:0] prod;
    prod = {16'd0, edges} * scale;
    return (prod > 32'h0000_FFFF) ? RPM_MAX : prod[RPM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mgmt_tach_channel.sv
// One tach channel: synchroniser, debounce, gated edge counter, RPM conversion,
// optional 4-deep averaging (MGMT_TACH_AVERAGE_EN) and sticky stall detection.
module mgmt_tach_channel
  import mgmt_tach_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STALL_WINDOWS   = 4,
  parameter int RPM_SCALE       = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tach,
  input  logic window_end,
  input  rpm_t min_rpm,
  input  logic stall_clear,
  output rpm_t rpm,
  output logic stall
);

  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_WINDOWS + 1);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);

  logic [1:0]         sync_reg;
  logic               level_reg, level_next;
  logic [DEB_W-1:0]   deb_cnt_reg, deb_cnt_next;
  logic               rise;
  logic [15:0]        edge_cnt_reg, edge_cnt_next;
  rpm_t               win_rpm, rpm_new, rpm_reg;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic               stall_reg, stall_next;

  // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    level_next   = level_reg;
    deb_cnt_next = '0;
    rise         = 1'b0;
    if (sync_reg[1] != level_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        level_next = sync_reg[1];
        rise       = sync_reg[1];
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  // An edge on the terminal cycle seeds the next window rather than being lost.
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    if (window_end) begin
      edge_cnt_next = {15'd0, rise};
    end else if (rise && (edge_cnt_reg != 16'hFFFF)) begin
      edge_cnt_next = edge_cnt_reg + 16'd1;
    end
  end

  assign win_rpm = sat_mul_rpm(edge_cnt_reg, 32'(RPM_SCALE));

`ifdef MGMT_TACH_AVERAGE_EN
  rpm_t                 hist_reg [AVG_DEPTH-1];
  logic [RPM_WIDTH+1:0] avg_sum;

  always_comb begin
    avg_sum = {2'b00, win_rpm};
    for (int k = 0; k < AVG_DEPTH - 1; k++) begin
      avg_sum = avg_sum + {2'b00, hist_reg[k]};
    end
  end

  assign rpm_new = rpm_t'(avg_sum >> AVG_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < AVG_DEPTH - 1; k++) hist_reg[k] <= '0;
    end else if (window_end) begin
      hist_reg[0] <= win_rpm;
      for (int k = 1; k < AVG_DEPTH - 1; k++) hist_reg[k] <= hist_reg[k-1];
    end
  end
`else
  assign rpm_new = win_rpm;
`endif

  // Set beats clear; the counter survives a clear so a dead fan re-flags next window.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (window_end) begin
      if (rpm_new < min_rpm) begin
        if (stall_cnt_reg != STALL_MAX) stall_cnt_next = stall_cnt_reg + 1'b1;
      end else begin
        stall_cnt_next = '0;
      end
    end
    stall_next = stall_reg;
    if (stall_clear) stall_next = 1'b0;
    if (window_end && (stall_cnt_next == STALL_MAX)) stall_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg      <= '0;
      level_reg     <= 1'b0;
      deb_cnt_reg   <= '0;
      edge_cnt_reg  <= '0;
      rpm_reg       <= '0;
      stall_cnt_reg <= '0;
      stall_reg     <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], tach};
      level_reg     <= level_next;
      deb_cnt_reg   <= deb_cnt_next;
      edge_cnt_reg  <= edge_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
      stall_reg     <= stall_next;
      if (window_end) rpm_reg <= rpm_new;
    end
  end

  assign rpm   = rpm_reg;
  assign stall = stall_reg;

endmodule

// File: rtl/mgmt_tach_bank.sv
// Multi-channel fan tachometer bank: shared gate window, per-channel RPM and stall,
// maskable irq. Define MGMT_TACH_AVERAGE_EN to report a 4-window running average.
module mgmt_tach_bank
  import mgmt_tach_pkg::*;
#(
  parameter int NUM_FANS        = 2,
  parameter int REFCLK_HZ       = 187500000,
  parameter int WINDOW_CYCLES   = 46875000,
  parameter int PULSES_PER_REV  = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STALL_WINDOWS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_FANS-1:0]           tach,
  input  logic [RPM_WIDTH-1:0]          min_rpm,
  input  logic [NUM_FANS-1:0]           stall_mask,
  input  logic [NUM_FANS-1:0]           stall_clear,
  output logic [RPM_WIDTH*NUM_FANS-1:0] rpm,
  output logic                          rpm_valid,
  output logic [NUM_FANS-1:0]           stall,
  output logic                          irq
);

  // 64-bit arithmetic: 60*REFCLK_HZ overflows 32 bits at the default clock.
  localparam longint unsigned RPM_NUM   = 64'd60 * 64'(REFCLK_HZ);
  localparam longint unsigned RPM_DEN   = 64'(WINDOW_CYCLES) * 64'(PULSES_PER_REV);
  localparam int              RPM_SCALE = int'(RPM_NUM / RPM_DEN);
  localparam int              WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  generate
    if (((RPM_NUM % RPM_DEN) != 0) || (RPM_SCALE == 0)) begin : g_bad_scale
      $error("mgmt_tach_bank: 60*REFCLK_HZ must divide exactly by WINDOW_CYCLES*PULSES_PER_REV to a nonzero scale");
    end
    if ((NUM_FANS < 1) || (NUM_FANS > 16)) begin : g_bad_fans
      $error("mgmt_tach_bank: NUM_FANS must be 1..16");
    end
  endgenerate

  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic             window_end;
  logic             rpm_valid_reg;
  logic             irq_reg;

  assign window_end   = (win_cnt_reg == WIN_LAST);
  assign win_cnt_next = window_end ? '0 : win_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_reg   <= '0;
      rpm_valid_reg <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      win_cnt_reg   <= win_cnt_next;
      rpm_valid_reg <= window_end;
      irq_reg       <= |(stall & stall_mask);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FANS; gi++) begin : g_chan
      mgmt_tach_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STALL_WINDOWS   (STALL_WINDOWS),
        .RPM_SCALE       (RPM_SCALE)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .tach        (tach[gi]),
        .window_end  (window_end),
        .min_rpm     (min_rpm),
        .stall_clear (stall_clear[gi]),
        .rpm         (rpm[RPM_WIDTH*gi +: RPM_WIDTH]),
        .stall       (stall[gi])
      );
    end
  endgenerate

  assign rpm_valid = rpm_valid_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_mgmt_tach_bank.sv
// Directed bench for mgmt_tach_bank: rate, debounce, stall/clear/mask, reset, saturation.
// Expected values follow the MGMT_TACH_AVERAGE_EN setting of the build.
module tb_mgmt_tach_bank;

`ifdef MGMT_TACH_AVERAGE_EN
  localparam int EXP_W2 = 150;
  localparam int EXP_W3 = 225;
  localparam int EXP_W7 = 300;
  localparam int EXP_W8 = 225;
`else
  localparam int EXP_W2 = 300;
  localparam int EXP_W3 = 300;
  localparam int EXP_W7 = 300;
  localparam int EXP_W8 = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  tach;
  logic [15:0] min_rpm;
  logic [1:0]  stall_mask;
  logic [1:0]  stall_clear;
  logic [31:0] rpm;
  logic        rpm_valid;
  logic [1:0]  stall;
  logic        irq;

  logic [0:0]  tach_sat;
  logic [15:0] sat_rpm;
  logic        sat_valid;
  logic [0:0]  sat_stall;
  logic        sat_irq;

  logic gen_start, glitch_en, fan0_on, period_on;
  int   tests_run, tests_failed;
  int   cyc;

  mgmt_tach_bank #(
    .NUM_FANS(2), .REFCLK_HZ(1000), .WINDOW_CYCLES(1000), .PULSES_PER_REV(2),
    .DEBOUNCE_CYCLES(4), .STALL_WINDOWS(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .tach(tach), .min_rpm(min_rpm),
    .stall_mask(stall_mask), .stall_clear(stall_clear),
    .rpm(rpm), .rpm_valid(rpm_valid), .stall(stall), .irq(irq)
  );

  // Longer window and no debounce so a fast toggle can exceed the 16-bit RPM range.
  mgmt_tach_bank #(
    .NUM_FANS(1), .REFCLK_HZ(5000), .WINDOW_CYCLES(5000), .PULSES_PER_REV(2),
    .DEBOUNCE_CYCLES(1), .STALL_WINDOWS(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .tach(tach_sat), .min_rpm(16'd0),
    .stall_mask(1'b0), .stall_clear(1'b0),
    .rpm(sat_rpm), .rpm_valid(sat_valid), .stall(sat_stall), .irq(sat_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tach_sat = 1'b0;
    forever begin
      @(negedge clk);
      tach_sat = ~tach_sat;
    end
  end

  // Fan0: 100-cycle period, optional 2-cycle glitches in each half, gated per period.
  initial begin
    tach[0] = 1'b0;
    wait (gen_start);
    forever begin
      period_on = fan0_on;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!period_on)  tach[0] = 1'b0;
        else if (i < 50) tach[0] = !(glitch_en && (i == 20 || i == 21));
        else             tach[0] = glitch_en && (i == 70 || i == 71);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!rpm_valid && cycles < 1200);
    if (!rpm_valid) check_eq("rpm_valid_timeout", 32'(rpm_valid), 32'd1);
  endtask

  task automatic wait_sat_valid();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sat_valid && n < 5200);
    if (!sat_valid) check_eq("sat_valid_timeout", 32'(sat_valid), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    gen_start    = 1'b0;
    glitch_en    = 1'b0;
    fan0_on      = 1'b1;
    period_on    = 1'b1;
    rst_n        = 1'b0;
    tach[1]      = 1'b0;
    min_rpm      = 16'd100;
    stall_mask   = 2'b11;
    stall_clear  = 2'b00;

    step(3);
    check_eq("reset_rpm", rpm, 32'd0);
    check_eq("reset_valid", 32'(rpm_valid), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_irq", 32'(irq), 32'd0);
    rst_n     = 1'b1;
    gen_start = 1'b1;

    wait_valid(cyc);
    check_eq("w1_period", 32'(cyc), 32'd1000);
    wait_valid(cyc);
    check_eq("w2_period", 32'(cyc), 32'd1000);
    check_eq("w2_rpm0", 32'(rpm[15:0]), 32'(EXP_W2));
    check_eq("w2_rpm1", 32'(rpm[31:16]), 32'd0);
    glitch_en = 1'b1;

    wait_valid(cyc);
    check_eq("w3_rpm0_glitch", 32'(rpm[15:0]), 32'(EXP_W3));
    step(1);
    check_eq("w3_valid_single", 32'(rpm_valid), 32'd0);

    wait_valid(cyc);
    check_eq("w4_irq_before", 32'(irq), 32'd0);
    step(1);
    check_eq("w4_stall", 32'(stall), 32'd2);
    check_eq("w4_irq", 32'(irq), 32'd1);

    step(100);
    stall_clear = 2'b10;
    step(1);
    stall_clear = 2'b00;
    check_eq("clear_stall", 32'(stall), 32'd0);
    step(1);
    check_eq("clear_irq", 32'(irq), 32'd0);

    wait_valid(cyc);
    step(1);
    check_eq("w5_reflag", 32'(stall), 32'd2);

    step(100);
    stall_clear = 2'b10;
    step(1);
    stall_clear = 2'b00;
    check_eq("w5_clear_again", 32'(stall), 32'd0);
    step(897);
    stall_clear = 2'b10;
    step(1);
    stall_clear = 2'b00;
    check_eq("setwin_valid", 32'(rpm_valid), 32'd1);
    check_eq("setwin_stall", 32'(stall), 32'd2);

    stall_mask = 2'b00;
    step(1);
    check_eq("mask_irq_off", 32'(irq), 32'd0);
    stall_mask = 2'b11;
    step(1);
    check_eq("mask_irq_on", 32'(irq), 32'd1);

    step(950);
    fan0_on = 1'b0;
    wait_valid(cyc);
    check_eq("w7_rpm0", 32'(rpm[15:0]), 32'(EXP_W7));
    wait_valid(cyc);
    check_eq("w8_rpm0_stopped", 32'(rpm[15:0]), 32'(EXP_W8));
    check_eq("w8_rpm1", 32'(rpm[31:16]), 32'd0);

    step(300);
    rst_n = 1'b0;
    step(1);
    check_eq("midrst_rpm", rpm, 32'd0);
    check_eq("midrst_valid", 32'(rpm_valid), 32'd0);
    check_eq("midrst_stall", 32'(stall), 32'd0);
    check_eq("midrst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    wait_valid(cyc);
    check_eq("midrst_first_valid", 32'(cyc), 32'd1000);

    for (int w = 0; w < 4; w++) wait_sat_valid();
    check_eq("sat_rpm", 32'(sat_rpm), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
